// File: rtl/stack_pkg.sv
// Shared types for the tower-stacking game core: FSM encoding, default geometry
// and the layer extent record.
package stack_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_MOVE  = 3'd1,
      ST_PAUSE = 3'd2,
      ST_DROP  = 3'd3,
      ST_OVER  = 3'd4
   } state_e;

   localparam int DEF_COLS   = 32;
   localparam int DEF_MAX_H  = 16;
   localparam int DEF_INIT_W = 8;

   // Fields are wide enough for any supported grid; users narrow them on read.
   localparam int LAYER_F_W = 16;

   typedef struct packed {
      logic [LAYER_F_W-1:0] x;
      logic [LAYER_F_W-1:0] w;
   } layer_t;

endpackage

// File: rtl/layer_store.sv
// Tower layer register file: one write port, one registered read port whose
// result is gated to zero for indices at or above the current height.
module layer_store
   import stack_pkg::*;
#(
   parameter int MAX_H = DEF_MAX_H,
   parameter int X_W   = 5,
   parameter int W_W   = 6,
   parameter int H_W   = 5,
   parameter int IDX_W = (MAX_H > 1) ? $clog2(MAX_H) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [X_W-1:0]   wr_x,
   input  logic [W_W-1:0]   wr_w,
   input  logic [H_W-1:0]   height,
   input  logic [H_W-1:0]   rd_idx,
   output logic             rd_valid,
   output logic [X_W-1:0]   rd_x,
   output logic [W_W-1:0]   rd_w
);

   localparam int DEPTH = 1 << IDX_W;

   logic [X_W-1:0] mem_x_q [DEPTH];
   logic [W_W-1:0] mem_w_q [DEPTH];

   logic           rd_valid_q, rd_valid_d;
   logic [X_W-1:0] rd_x_q, rd_x_d;
   logic [W_W-1:0] rd_w_q, rd_w_d;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_x_q[wr_idx] <= wr_x;
         mem_w_q[wr_idx] <= wr_w;
      end
   end

   // Height is the pre-write value, so a same-cycle write/read of one index reads invalid.
   always_comb begin
      rd_valid_d = (rd_idx < height);
      rd_x_d     = '0;
      rd_w_d     = '0;
      if (rd_valid_d) begin
         rd_x_d = mem_x_q[rd_idx[IDX_W-1:0]];
         rd_w_d = mem_w_q[rd_idx[IDX_W-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_x_q     <= '0;
         rd_w_q     <= '0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_x_q     <= rd_x_d;
         rd_w_q     <= rd_w_d;
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_x     = rd_x_q;
   assign rd_w     = rd_w_q;

endmodule

// File: rtl/stack_engine.sv
// Tower-stacking game core: sliding block with edge bounce, overlap trimming on
// drop, score and game-over/win detection around a layer register file.
module stack_engine
   import stack_pkg::*;
#(
   parameter int COLS   = DEF_COLS,
   parameter int MAX_H  = DEF_MAX_H,
   parameter int INIT_W = DEF_INIT_W,
   localparam int X_W = $clog2(COLS),
   localparam int W_W = $clog2(COLS + 1),
   localparam int H_W = $clog2(MAX_H + 1),
   localparam int S_W = $clog2(MAX_H * INIT_W + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           pause,
   input  logic           drop,
   input  logic           tick,
   input  logic [H_W-1:0] rd_idx,
   output logic           rd_valid,
   output logic [X_W-1:0] rd_x,
   output logic [W_W-1:0] rd_w,
   output logic [X_W-1:0] cur_x,
   output logic [W_W-1:0] cur_w,
   output logic [H_W-1:0] height,
   output logic [S_W-1:0] score,
   output logic [2:0]     state,
   output logic           game_over,
   output logic           win
);

   localparam int A_W    = W_W + 1;
   localparam int IDX_W  = (MAX_H > 1) ? $clog2(MAX_H) : 1;
   localparam int BASE_X = (COLS - INIT_W) / 2;

   state_e         state_q, state_d;
   logic [X_W-1:0] cur_x_q, cur_x_d;
   logic [W_W-1:0] cur_w_q, cur_w_d;
   logic           dir_right_q, dir_right_d;
   layer_t         top_q, top_d;
   logic [H_W-1:0] height_q, height_d;
   logic [S_W-1:0] score_q, score_d;
   logic           win_q, win_d;

   logic             we;
   logic [IDX_W-1:0] wr_idx;
   logic [X_W-1:0]   wr_x;
   logic [W_W-1:0]   wr_w;

   logic [A_W-1:0] cur_end, top_end, lo, hi, ov_w;
   logic           hit, last;

   // Overlap unit, widened by one bit so extents past the grid edge never wrap.
   always_comb begin
      cur_end = A_W'(cur_x_q) + A_W'(cur_w_q);
      top_end = A_W'(top_q.x) + A_W'(top_q.w);
      lo      = (A_W'(cur_x_q) > A_W'(top_q.x)) ? A_W'(cur_x_q) : A_W'(top_q.x);
      hi      = (cur_end < top_end) ? cur_end : top_end;
      hit     = (hi > lo);
      ov_w    = hi - lo;
      last    = ((height_q + H_W'(1)) == H_W'(MAX_H));
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_OVER: if (start) state_d = ST_MOVE;
         ST_MOVE: begin
            if (pause)     state_d = ST_PAUSE;
            else if (drop) state_d = ST_DROP;
         end
         ST_PAUSE: if (pause) state_d = ST_MOVE;
         ST_DROP:  state_d = (!hit || last) ? ST_OVER : ST_MOVE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      state     = state_q;
      game_over = (state_q == ST_OVER);
   end

   always_comb begin
      cur_x_d     = cur_x_q;
      cur_w_d     = cur_w_q;
      dir_right_d = dir_right_q;
      top_d       = top_q;
      height_d    = height_q;
      score_d     = score_q;
      win_d       = win_q;
      we          = 1'b0;
      wr_idx      = height_q[IDX_W-1:0];
      wr_x        = lo[X_W-1:0];
      wr_w        = ov_w[W_W-1:0];
      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (start) begin
               we          = 1'b1;
               wr_idx      = '0;
               wr_x        = X_W'(BASE_X);
               wr_w        = W_W'(INIT_W);
               top_d.x     = LAYER_F_W'(BASE_X);
               top_d.w     = LAYER_F_W'(INIT_W);
               height_d    = H_W'(1);
               score_d     = '0;
               win_d       = 1'b0;
               cur_x_d     = '0;
               cur_w_d     = W_W'(INIT_W);
               dir_right_d = 1'b1;
            end
         end
         ST_MOVE: begin
            // A tick coinciding with pause or drop is discarded.
            if (tick && !pause && !drop) begin
               if (dir_right_q) begin
                  if (cur_end == A_W'(COLS)) begin
                     dir_right_d = 1'b0;
                     cur_x_d     = cur_x_q - X_W'(1);
                  end else begin
                     cur_x_d = cur_x_q + X_W'(1);
                  end
               end else begin
                  if (cur_x_q == '0) begin
                     dir_right_d = 1'b1;
                     cur_x_d     = cur_x_q + X_W'(1);
                  end else begin
                     cur_x_d = cur_x_q - X_W'(1);
                  end
               end
            end
         end
         ST_DROP: begin
            if (hit) begin
               we       = 1'b1;
               top_d.x  = LAYER_F_W'(lo);
               top_d.w  = LAYER_F_W'(ov_w);
               height_d = height_q + H_W'(1);
               score_d  = score_q + S_W'(ov_w);
               if (last) begin
                  win_d = 1'b1;
               end else begin
                  cur_x_d     = '0;
                  cur_w_d     = ov_w[W_W-1:0];
                  dir_right_d = 1'b1;
               end
            end else begin
               win_d = 1'b0;
            end
         end
         default: ;
      endcase
      if (rst) we = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_x_q     <= '0;
         cur_w_q     <= W_W'(INIT_W);
         dir_right_q <= 1'b1;
         height_q    <= '0;
         score_q     <= '0;
         win_q       <= 1'b0;
      end else begin
         cur_x_q     <= cur_x_d;
         cur_w_q     <= cur_w_d;
         dir_right_q <= dir_right_d;
         height_q    <= height_d;
         score_q     <= score_d;
         win_q       <= win_d;
      end
   end

   // Top extent is always rewritten by start before it is consumed.
   always_ff @(posedge clk) begin
      top_q <= top_d;
   end

   layer_store #(
      .MAX_H (MAX_H),
      .X_W   (X_W),
      .W_W   (W_W),
      .H_W   (H_W),
      .IDX_W (IDX_W)
   ) u_store (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .wr_idx   (wr_idx),
      .wr_x     (wr_x),
      .wr_w     (wr_w),
      .height   (height_q),
      .rd_idx   (rd_idx),
      .rd_valid (rd_valid),
      .rd_x     (rd_x),
      .rd_w     (rd_w)
   );

   assign cur_x  = cur_x_q;
   assign cur_w  = cur_w_q;
   assign height = height_q;
   assign score  = score_q;
   assign win    = win_q;

endmodule

// File: tb/tb_stack_engine.sv
// Bench for stack_engine: directed game scenarios with literal expectations plus
// randomized play, all compared each cycle against an integer game model.
module tb_stack_engine;

   localparam int COLS   = 32;
   localparam int MAX_H  = 16;
   localparam int INIT_W = 8;
   localparam int S_IDLE = 0, S_MOVE = 1, S_PAUSE = 2, S_DROP = 3, S_OVER = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1, start = 1'b0, pause = 1'b0, drop = 1'b0, tick = 1'b0;
   logic [4:0] rd_idx = '0;
   logic       rd_valid, game_over, win;
   logic [4:0] rd_x, cur_x, height;
   logic [5:0] rd_w, cur_w;
   logic [7:0] score;
   logic [2:0] state;

   stack_engine dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .drop(drop), .tick(tick),
      .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_x(rd_x), .rd_w(rd_w),
      .cur_x(cur_x), .cur_w(cur_w), .height(height), .score(score),
      .state(state), .game_over(game_over), .win(win)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Game model: plain integers, signed direction, arrays of placed layers.
   int m_state, m_h, m_x, m_w, m_dir, m_score, m_win, m_tx, m_tw;
   int m_lx[MAX_H], m_lw[MAX_H];
   int e_rv, e_rx, e_rw;
   bit m_ok = 1'b0;

   always @(posedge clk) begin : model
      int lo, hi, nx, ri;
      if (rst) begin
         m_state = S_IDLE; m_h = 0; m_x = 0; m_w = INIT_W; m_dir = 1;
         m_score = 0; m_win = 0; e_rv = 0; e_rx = 0; e_rw = 0;
         m_ok = 1'b1;
      end else begin
         ri = int'(rd_idx);
         e_rv = (ri < m_h) ? 1 : 0;
         e_rx = 0; e_rw = 0;
         if (e_rv == 1) begin e_rx = m_lx[ri]; e_rw = m_lw[ri]; end
         case (m_state)
            S_IDLE, S_OVER: if (start) begin
               m_lx[0] = (COLS - INIT_W) / 2; m_lw[0] = INIT_W;
               m_tx = m_lx[0]; m_tw = INIT_W;
               m_h = 1; m_score = 0; m_win = 0;
               m_x = 0; m_w = INIT_W; m_dir = 1; m_state = S_MOVE;
            end
            S_MOVE: begin
               if (pause) m_state = S_PAUSE;
               else if (drop) m_state = S_DROP;
               else if (tick) begin
                  nx = m_x + m_dir;
                  if (nx < 0 || nx + m_w > COLS) begin
                     m_dir = -m_dir;
                     nx = m_x + m_dir;
                  end
                  m_x = nx;
               end
            end
            S_PAUSE: if (pause) m_state = S_MOVE;
            S_DROP: begin
               lo = (m_x > m_tx) ? m_x : m_tx;
               hi = (m_x + m_w < m_tx + m_tw) ? m_x + m_w : m_tx + m_tw;
               if (hi <= lo) begin
                  m_win = 0; m_state = S_OVER;
               end else begin
                  m_lx[m_h] = lo; m_lw[m_h] = hi - lo;
                  m_tx = lo; m_tw = hi - lo;
                  m_h++; m_score += hi - lo;
                  if (m_h == MAX_H) begin
                     m_win = 1; m_state = S_OVER;
                  end else begin
                     m_w = hi - lo; m_x = 0; m_dir = 1; m_state = S_MOVE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("m_state", int'(state), m_state);
         chk("m_height", int'(height), m_h);
         chk("m_cur_x", int'(cur_x), m_x);
         chk("m_cur_w", int'(cur_w), m_w);
         chk("m_score", int'(score), m_score);
         chk("m_game_over", int'(game_over), (m_state == S_OVER) ? 1 : 0);
         chk("m_win", int'(win), m_win);
         chk("m_rd_valid", int'(rd_valid), e_rv);
         chk("m_rd_x", int'(rd_x), e_rx);
         chk("m_rd_w", int'(rd_w), e_rw);
      end
   end

   task automatic step(input bit r, input bit s, input bit p, input bit d, input bit t);
      rst = r; start = s; pause = p; drop = d; tick = t;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0);
   endtask

   task automatic ticks(input int n);
      repeat (n) step(0, 0, 0, 0, 1);
   endtask

   task automatic new_game();
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_state"}, int'(state), S_IDLE);
      chk({tag, "_height"}, int'(height), 0);
      chk({tag, "_cur_x"}, int'(cur_x), 0);
      chk({tag, "_cur_w"}, int'(cur_w), 8);
      chk({tag, "_score"}, int'(score), 0);
      chk({tag, "_game_over"}, int'(game_over), 0);
      chk({tag, "_win"}, int'(win), 0);
      chk({tag, "_rd_valid"}, int'(rd_valid), 0);
      chk({tag, "_rd_w"}, int'(rd_w), 0);
   endtask

   initial begin
      step(1, 0, 0, 0, 0);
      chk_reset("rst0");

      // Start: base layer centred at 12.
      step(0, 1, 0, 0, 0);
      chk("start_state", int'(state), S_MOVE);
      chk("start_height", int'(height), 1);
      chk("start_cur_w", int'(cur_w), 8);
      rd_idx = 5'd0; idle();
      chk("rd0_valid", int'(rd_valid), 1);
      chk("rd0_x", int'(rd_x), 12);
      chk("rd0_w", int'(rd_w), 8);
      rd_idx = 5'd1; idle();
      chk("rd1_valid", int'(rd_valid), 0);

      // Aligned drop.
      ticks(12);
      chk("al_x", int'(cur_x), 12);
      step(0, 0, 0, 1, 0);
      chk("al_drop_state", int'(state), S_DROP);
      idle();
      chk("al_height", int'(height), 2);
      chk("al_score", int'(score), 8);
      chk("al_cur_x", int'(cur_x), 0);
      chk("al_cur_w", int'(cur_w), 8);
      idle();
      chk("al_rd_x", int'(rd_x), 12);
      chk("al_rd_w", int'(rd_w), 8);

      // Trimmed drop, then a miss.
      new_game();
      ticks(15);
      step(0, 0, 0, 1, 0);
      idle();
      chk("tr_score", int'(score), 5);
      chk("tr_cur_w", int'(cur_w), 5);
      rd_idx = 5'd1; idle();
      chk("tr_rd_x", int'(rd_x), 15);
      chk("tr_rd_w", int'(rd_w), 5);
      step(0, 0, 0, 1, 0);
      idle();
      chk("miss_state", int'(state), S_OVER);
      chk("miss_game_over", int'(game_over), 1);
      chk("miss_win", int'(win), 0);
      chk("miss_height", int'(height), 2);
      step(0, 1, 0, 0, 0);
      chk("restart_height", int'(height), 1);
      chk("restart_score", int'(score), 0);

      // Bounce at both edges.
      ticks(24);
      chk("bounce_r_at", int'(cur_x), 24);
      ticks(1);
      chk("bounce_r_after", int'(cur_x), 23);
      ticks(23);
      chk("bounce_l_at", int'(cur_x), 0);
      ticks(1);
      chk("bounce_l_after", int'(cur_x), 1);

      // Pause behaviour and simultaneous events.
      new_game();
      step(0, 0, 1, 0, 0);
      chk("pause_state", int'(state), S_PAUSE);
      ticks(10);
      step(0, 0, 0, 1, 0);
      chk("pause_cur_x", int'(cur_x), 0);
      chk("pause_height", int'(height), 1);
      step(0, 0, 1, 0, 0);
      chk("resume_state", int'(state), S_MOVE);
      step(0, 0, 1, 1, 0);
      idle();
      chk("pd_state", int'(state), S_PAUSE);
      chk("pd_height", int'(height), 1);
      step(0, 0, 1, 0, 0);
      ticks(12);
      step(0, 0, 0, 1, 1);
      idle();
      chk("dt_score", int'(score), 8);
      chk("dt_cur_w", int'(cur_w), 8);

      // Win after 15 aligned drops, then reset in a DROP cycle.
      new_game();
      repeat (15) begin
         ticks(12);
         step(0, 0, 0, 1, 0);
         idle();
      end
      chk("win_height", int'(height), 16);
      chk("win_score", int'(score), 120);
      chk("win_game_over", int'(game_over), 1);
      chk("win_win", int'(win), 1);
      step(0, 1, 0, 0, 0);
      ticks(12);
      step(0, 0, 0, 1, 0);
      chk("rd_drop_state", int'(state), S_DROP);
      step(1, 0, 0, 0, 0);
      chk_reset("rst_drop");

      // Randomized play.
      for (int i = 0; i < 4000; i++) begin
         rd_idx = 5'($urandom_range(0, 17));
         step($urandom_range(0, 499) == 0, $urandom_range(0, 39) == 0,
              $urandom_range(0, 29) == 0, $urandom_range(0, 14) == 0,
              $urandom_range(0, 1) == 0);
      end
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/stack_engine.md
# stack_engine

Parametrised game core for the tower-stacking game. It owns the sliding block, the stored tower layers, overlap trimming on each drop, score, and game-over/win detection. It sits between the clock divider (movement `tick`) and the VGA draw block, which reads layers through a synchronous read port. It is the successor to the fixed-size stack logic, adding grid width, tower depth, initial width, pause, bounce, trimming and a win condition.

## Interface
Parameters:
- `COLS`, 32: grid width in columns; requires `INIT_W < COLS`.
- `MAX_H`, 16: tower height, counted in layers and including the base, at which the player wins.
- `INIT_W`, 8: initial block width in columns.
- Derived: `X_W = $clog2(COLS)`, `W_W = $clog2(COLS+1)`, `H_W = $clog2(MAX_H+1)`, `S_W = $clog2(MAX_H*INIT_W+1)`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. **One clock; reset is synchronous and active-high.**
- `start`  in  1  single-cycle pulse (debounced upstream); begins or restarts a game.
- `pause`  in  1  single-cycle pulse; toggles pause.
- `drop`  in  1  single-cycle pulse; places the moving block.
- `tick`  in  1  movement enable, one column per asserted cycle.
- `rd_idx`  in  H_W  layer index requested by draw.
- `rd_valid`  out  1  `rd_idx < height`, registered.
- `rd_x`  out  X_W  left column of the requested layer; 0 when not valid.
- `rd_w`  out  W_W  width of the requested layer; 0 when not valid.
- `cur_x`  out  X_W  moving block left column.
- `cur_w`  out  W_W  moving block width.
- `height`  out  H_W  number of stored layers.
- `score`  out  S_W  sum of all placed widths, excluding the base.
- `state`  out  3  FSM state.
- `game_over`  out  1  asserted in OVER.
- `win`  out  1  asserted in OVER when the height limit was reached.

## Operation
- States: IDLE=0, MOVE=1, PAUSE=2, DROP=3, OVER=4.
- **IDLE, or OVER, on `start`:**
  - Layer 0 is set to x=(COLS-INIT_W)/2, w=INIT_W.
  - height=1, score=0, win=0, game_over=0.
  - Moving block: cur_x=0, cur_w=INIT_W, direction right.
  - Next state MOVE.
- **MOVE:** each `tick` advances cur_x one column in the current direction.
  - Right edge: when moving right with cur_x+cur_w==COLS, the direction flips and cur_x decrements on that same tick.
  - Left edge: when moving left with cur_x==0, the direction flips and cur_x increments.
- **MOVE, on `drop`:** go to DROP. The top layer's extent (top_x, top_w) is held in dedicated registers, not read from the store.
- **DROP** (exactly one cycle):
  - Compute lo=max(cur_x, top_x) and hi=min(cur_x+cur_w, top_x+top_w).
  - If hi<=lo: go to OVER with win=0. Nothing is stored.
  - Otherwise:
    - Write layer[height] = (lo, hi-lo).
    - top is updated to (lo, hi-lo); height+=1; score+=hi-lo.
    - If the new height==MAX_H: go to OVER with win=1.
    - Else: cur_w=hi-lo, cur_x=0, direction right, go to MOVE.
- **PAUSE:** `pause` in MOVE enters PAUSE; `pause` in PAUSE returns to MOVE. `tick` and `drop` are ignored while paused.
- **Ignored inputs:**
  - `start` in MOVE, PAUSE and DROP.
  - `pause` in IDLE, DROP and OVER.
  - `drop` outside MOVE.
- **Simultaneous events in MOVE:**
  - `drop` and `tick` in the same cycle: drop uses the pre-tick position and the tick is discarded.
  - `pause` and `drop` in the same cycle: pause wins and the drop is discarded.
- **Reset:** `rst` overrides every input in every state, including mid-DROP.
- **Arithmetic:** all overlap arithmetic is unsigned at W_W+1 bits, so cur_x+cur_w cannot overflow. Score cannot overflow by construction.

## Timing
- Reset values: state=IDLE, height=0, cur_x=0, cur_w=INIT_W, score=0, game_over=0, win=0, rd_valid=0, rd_x=0, rd_w=0. Direction resets to right.
- Drop latency:
  - `drop` sampled at edge N puts state=DROP after N.
  - Layer store, height, score, cur_x/cur_w and state update at edge N+1.
  - A read of the new layer index presented after N+1 returns it after N+2.
- Read port: 1-cycle latency from `rd_idx` to rd_valid/rd_x/rd_w. A write and a read of the same index in one cycle returns the old (invalid) value.
- `tick` moves cur_x in the cycle following the edge that samples it. There are no combinational paths from inputs to outputs.

## Structure
- Package `stack_pkg`:
  - state enum and encodings;
  - default values of COLS/MAX_H/INIT_W;
  - a layer struct {x, w}.
- Sub-module `layer_store`: MAX_H×(X_W+W_W) register file with one write port and one registered read port, plus index-range gating for rd_valid.
- The FSM, movement, overlap unit and score counter stay in `stack_engine`.

## Test plan
All scenarios use default parameters (COLS=32, MAX_H=16, INIT_W=8).
- **Reset, then start:** state=MOVE, height=1, cur_x=0, cur_w=8; rd_idx=0 returns x=12, w=8, valid=1; rd_idx=1 returns valid=0.
- **Aligned drop:** 12 ticks, then drop → layer1=(12,8), height=2, score=8, cur_x=0, cur_w=8, two cycles after drop.
- **Trimmed drop:** 15 ticks, then drop → layer1=(15,5), score=5, cur_w=5. Then a drop at x=0 gives no overlap → game_over=1, win=0, height=2. `start` then restarts with height=1, score=0.
- **Right-edge bounce:** 24 ticks reach x=24; the 25th tick gives x=23 moving left. Continuing, a tick at x=0 gives x=1.
- **Pause:**
  - Pause, then 10 ticks and a drop → cur_x and height frozen.
  - Pause again → resumes.
  - Drop+pause in the same cycle → PAUSE, no layer written.
  - Drop+tick in the same cycle → pre-tick x is used.
- **Win, then reset:** 15 aligned drops → height=16, score=120, game_over=1, win=1. `rst` during the next game's DROP cycle → all outputs at reset values, height=0.
